// File: rtl/bus_slave_port.sv
// Bit-serial bus slave: mode bit, LSB-first address and write data in,
// LSB-first read data out, backed by a local word memory.
module bus_slave_port #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 2048
) (
  input  logic clk,
  input  logic rstn,
  input  logic mvalid,
  input  logic mwdata,
  output logic sready,
  output logic srvalid,
  output logic srdata
);
  localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RREAD, RDATA} state_t;

  state_t             state;
  logic               mode;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wsh;
  logic [DATA_W-1:0]  rsh;
  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  logic               in_range;
  logic [MEM_AW-1:0]  mem_idx;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  rsh_nxt;

  // Out-of-range addresses drop writes and read back as zero.
  assign in_range = 32'(addr) < 32'(MEM_DEPTH);
  assign mem_idx  = MEM_AW'(addr);
  assign rd_word  = in_range ? mem[mem_idx] : '0;
  assign rsh_nxt  = rsh >> 1;

  // Memory has no reset so committed writes survive it.
  always_ff @(posedge clk) begin
    if (state == WRITE && in_range) mem[mem_idx] <= wsh;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      mode    <= 1'b0;
      cnt     <= '0;
      addr    <= '0;
      wsh     <= '0;
      rsh     <= '0;
      sready  <= 1'b1;
      srvalid <= 1'b0;
      srdata  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mvalid) begin
          mode   <= mwdata;
          cnt    <= '0;
          sready <= 1'b0;
          state  <= ADDR;
        end
        ADDR: if (mvalid) begin
          addr <= {mwdata, addr[ADDR_W-1:1]};
          if (cnt == CNT_W'(ADDR_W - 1)) begin
            cnt   <= '0;
            state <= mode ? WDATA : RREAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WDATA: if (mvalid) begin
          wsh <= {mwdata, wsh[DATA_W-1:1]};
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt   <= '0;
            state <= WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          sready <= 1'b1;
          state  <= IDLE;
        end
        RREAD: begin
          rsh     <= rd_word;
          srvalid <= 1'b1;
          srdata  <= rd_word[0];
          cnt     <= '0;
          state   <= RDATA;
        end
        RDATA: begin
          rsh <= rsh_nxt;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt     <= '0;
            srvalid <= 1'b0;
            srdata  <= 1'b0;
            sready  <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt    <= cnt + 1'b1;
            srdata <= rsh_nxt[0];
          end
        end
        default: begin
          state  <= IDLE;
          sready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_slave_port.sv
// Scoreboard bench for bus_slave_port: stimulus pushes expected read bits
// (value and cycle), a negedge monitor pops and compares them.
module tb_bus_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mvalid = 1'b0;
  logic mwdata = 1'b0;
  logic sready, srvalid, srdata;

  bus_slave_port #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(2048)) dut (
    .clk(clk), .rstn(rstn), .mvalid(mvalid), .mwdata(mwdata),
    .sready(sready), .srvalid(srvalid), .srdata(srdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic b; int cyc;} exp_t;
  exp_t q[$];

  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  int   exp_ready_cyc = -1;
  int   last_t0 = 0;
  bit   noise = 1'b0;
  logic [DW-1:0] model [4096];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (srvalid) begin
        if (q.size() == 0) begin
          check("unexpected_srvalid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("srdata_bit", int'(srdata), int'(e.b));
          check("srvalid_cycle", cyc, e.cyc);
        end
      end else begin
        check("srdata_idle_zero", int'(srdata), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int stall_after, input int stall_n, input int abort_at);
    int n = 0;
    int stall = 0;
    int nb;
    int t0;
    logic [AW+DW:0] seq;
    logic [DW-1:0] rd;
    while (!sready && n < 200) begin
      if (noise) begin
        mvalid = ~mvalid;
        mwdata = 1'($urandom);
      end else begin
        mvalid = 1'b0;
      end
      tick();
      n++;
    end
    if (!sready) begin
      check("sready_timeout", 0, 1);
      return;
    end
    if (exp_ready_cyc >= 0) check("sready_cycle", cyc, exp_ready_cyc);
    t0 = cyc;
    last_t0 = t0;
    seq = {d, a, wr};
    nb = 1 + AW + (wr ? DW : 0);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        rstn = 1'b0;
        mvalid = 1'b0;
        tick();
        rstn = 1'b1;
        exp_ready_cyc = -1;
        return;
      end
      mvalid = 1'b1;
      mwdata = seq[i];
      tick();
      if (stall_n > 0 && i == stall_after + 1) begin
        mvalid = 1'b0;
        repeat (stall_n) tick();
        stall = stall_n;
      end
    end
    mvalid = 1'b0;
    if (wr) begin
      if (a < 12'h800) model[a] = d;
    end else begin
      rd = (a < 12'h800) ? model[a] : '0;
      for (int i = 0; i < DW; i++) begin
        exp_t e;
        e.b = rd[i];
        e.cyc = t0 + AW + 2 + stall + i;
        q.push_back(e);
      end
    end
    exp_ready_cyc = t0 + AW + DW + 2 + stall;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model[i] = '0;
    repeat (3) tick();
    check("reset_sready", int'(sready), 1);
    check("reset_srvalid", int'(srvalid), 0);
    check("reset_srdata", int'(srdata), 0);
    rstn = 1'b1;
    tick();

    send_tx(1'b1, 12'h000, 8'h5A, 0, 0, -1);
    send_tx(1'b1, 12'h0A5, 8'h3C, 0, 0, -1);
    send_tx(1'b0, 12'h0A5, 8'h00, 0, 0, -1);      // expect 0,0,1,1,1,1,0,0
    send_tx(1'b0, 12'h0A5, 8'h00, 5, 3, -1);      // stall after address bit 5
    send_tx(1'b1, 12'h800, 8'hFF, 0, 0, -1);      // out of range, dropped
    send_tx(1'b0, 12'h800, 8'h00, 0, 0, -1);
    send_tx(1'b0, 12'h000, 8'h00, 0, 0, -1);      // still 0x5A
    send_tx(1'b1, 12'h7FF, 8'hA1, 0, 0, -1);
    send_tx(1'b0, 12'h7FF, 8'h00, 0, 0, -1);

    // Reset during the 4th read bit.
    send_tx(1'b0, 12'h0A5, 8'h00, 0, 0, -1);
    repeat (4) tick();
    check("abort_cycle", cyc, last_t0 + AW + 2 + 3);
    rstn = 1'b0;
    #1;
    check("abort_srvalid", int'(srvalid), 0);
    check("abort_sready", int'(sready), 1);
    check("abort_srdata", int'(srdata), 0);
    check("abort_pending_bits", q.size(), 5);
    q.delete();
    tick();
    rstn = 1'b1;
    exp_ready_cyc = -1;
    send_tx(1'b0, 12'h0A5, 8'h00, 0, 0, -1);      // survives reset: 0x3C

    // Partial write aborted in the data phase leaves memory intact.
    send_tx(1'b1, 12'h0A5, 8'h00, 0, 0, 15);
    send_tx(1'b0, 12'h0A5, 8'h00, 0, 0, -1);

    // mvalid toggling during RDATA, then back-to-back write.
    send_tx(1'b1, 12'h123, 8'h96, 0, 0, -1);
    noise = 1'b1;
    send_tx(1'b0, 12'h123, 8'h00, 0, 0, -1);
    send_tx(1'b1, 12'h124, 8'h69, 0, 0, -1);
    noise = 1'b0;
    send_tx(1'b0, 12'h124, 8'h00, 0, 0, -1);
    send_tx(1'b0, 12'h123, 8'h00, 0, 0, -1);

    for (int n = 0; n < 100 && (q.size() != 0 || !sready); n++) tick();
    check("queue_drained", q.size(), 0);
    check("final_sready", int'(sready), 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
